mem_arbiter: RTL and testbench

Round-robin arbiter sharing the single memory port between the graph reader, writer and other memory masters of the Dijkstra engine. Each master uses the four-phase enable/ready handshake: enable high, memory ready high, enable low, memory ready low. The arbiter grants one master per transaction and passes its address, data and enables through to memory. Non-granted masters see ready=0. Memory-side outputs are always driven; masters never tri-state the bus.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_rr_select.sv | 26 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding, requester
// index width and a one-hot to index helper.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Upper bound on requesters; indices always carried at this width.
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after i_last, wrapping
// modulo NUM_REQ. o_valid is low when nothing is requesting.
module rr_select
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_pick,
  output logic               o_valid
);

  // Scan offsets 1..NUM_REQ from the last owner; the first hit wins.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      for (int j = 0; j < NUM_REQ; j++)
        if (!o_valid && i_req[j] && (j == (int'(i_last) + k) % NUM_REQ)) begin
          o_pick[j] = 1'b1;
          o_valid   = 1'b1;
        end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared memory port (four-phase enable/ready).
// Optional watchdog: define MEM_ARBITER_TIMEOUT_EN to add the timeout counter
// and the sticky timeout_error output.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int MADDR_WIDTH    = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH    = `DEFAULT_MDATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_read_enable,
  input  logic [NUM_REQ-1:0]                  req_write_enable,
  input  logic [NUM_REQ-1:0][MADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][MDATA_WIDTH-1:0] req_write_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [MDATA_WIDTH-1:0]              req_read_data,
  output logic [NUM_REQ-1:0]                  grant,
  output logic                                mem_read_enable,
  output logic                                mem_write_enable,
  output logic [MADDR_WIDTH-1:0]              mem_addr,
  output logic [MDATA_WIDTH-1:0]              mem_write_data,
  input  logic [MDATA_WIDTH-1:0]              mem_read_data,
  input  logic                                mem_ready
`ifdef MEM_ARBITER_TIMEOUT_EN
  ,
  output logic                                timeout_error
`endif
);

  // Reject unsupported configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mem_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_t                 r_state, w_state_nxt;
  logic [NUM_REQ-1:0]         r_grant;
  logic [IDX_W-1:0]           r_last;
  logic [NUM_REQ-1:0]         w_req_raw, w_req, w_pick;
  logic                       w_valid, w_busy, w_to;
  logic                       w_g_rd, w_g_wr;
  logic [MADDR_WIDTH-1:0]     w_g_addr;
  logic [MDATA_WIDTH-1:0]     w_g_data;

  assign w_req_raw     = req_read_enable | req_write_enable;
  assign grant         = r_grant;
  assign req_read_data = mem_read_data;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_block;
  logic               r_timeout;

  // A faulted master stays out of arbitration until it drops its enables.
  assign w_req         = w_req_raw & ~r_block;
  assign w_to          = (r_state == ACTIVE) && !mem_ready &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_error = r_timeout;

  // Watchdog counter, sticky error flag and faulted-master mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_block   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state != ACTIVE) r_cnt <= '0;
      else if (!mem_ready)   r_cnt <= r_cnt + 1'b1;
      r_block <= (r_block & w_req_raw) | (w_to ? r_grant : '0);
      if (w_to) r_timeout <= 1'b1;
    end
  end
`else
  assign w_req = w_req_raw;
  assign w_to  = 1'b0;
`endif

  // Select the granted master's request fields (one-hot OR mux).
  always_comb begin
    w_g_rd   = 1'b0;
    w_g_wr   = 1'b0;
    w_g_addr = '0;
    w_g_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (r_grant[i]) begin
        w_g_rd   = w_g_rd   | req_read_enable[i];
        w_g_wr   = w_g_wr   | req_write_enable[i];
        w_g_addr = w_g_addr | req_addr[i];
        w_g_data = w_g_data | req_write_data[i];
      end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and memory-side outputs; write wins when both enables are set.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      IDLE:    if (w_valid) w_state_nxt = ACTIVE;
      ACTIVE: begin
        w_busy = 1'b1;
        if (w_to)           w_state_nxt = IDLE;
        else if (mem_ready) w_state_nxt = RELEASE;
      end
      RELEASE: begin
        w_busy = 1'b1;
        if (!w_g_rd && !w_g_wr && !mem_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    mem_read_enable  = w_busy & w_g_rd & ~w_g_wr;
    mem_write_enable = w_busy & w_g_wr;
    mem_addr         = w_busy ? w_g_addr : '0;
    mem_write_data   = w_busy ? w_g_data : '0;
    req_ready        = w_busy ? (r_grant & {NUM_REQ{mem_ready}}) : '0;
  end

  // Grant register and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
    end else if (r_state == IDLE && w_valid) begin
      r_grant <= w_pick;
    end else if (r_state != IDLE && w_state_nxt == IDLE) begin
      r_last  <= oh_to_idx(MAX_REQ'(r_grant));
      r_grant <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a four-phase memory responder pops a
// scoreboard of expected transactions; per-scenario tasks do inline checks.
module tb_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic                 clock, reset;
  logic [N-1:0]         rd, wr;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0]         req_ready, grant;
  logic [DW-1:0]        req_read_data, mem_read_data, mem_write_data;
  logic                 mem_read_enable, mem_write_enable, mem_ready;
  logic [AW-1:0]        mem_addr;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic                 timeout_error;
`endif

  logic resp_en;
  int   checks, errors;

  typedef struct {
    logic [N-1:0]  g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    logic          re;
  } exp_t;
  exp_t sb[$];
  int   glog[$];

  mem_arbiter #(
    .NUM_REQ(N), .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_read_enable(rd), .req_write_enable(wr),
    .req_addr(addr), .req_write_data(wdata),
    .req_ready(req_ready), .req_read_data(req_read_data), .grant(grant),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
`ifdef MEM_ARBITER_TIMEOUT_EN
    , .timeout_error(timeout_error)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory model: raise ready one half-cycle after a new enable, drop it
  // once enables are gone; each accepted access is checked against the queue.
  initial begin
    mem_ready = 1'b0;
    mem_read_data = '0;
    forever begin
      @(negedge clock);
      if (reset) mem_ready = 1'b0;
      else if (resp_en && (mem_read_enable || mem_write_enable) && !mem_ready) begin
        exp_t e;
        int   gi;
        gi = -1;
        for (int i = 0; i < N; i++) if (grant[i]) gi = i;
        glog.push_back(gi);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: unexpected access grant=%b addr=%h", grant, mem_addr);
        end else begin
          e = sb.pop_front();
          checks += 4;
          if (grant !== e.g) begin errors++; $display("FAIL sb_grant: got %b expected %b", grant, e.g); end
          if (mem_addr !== e.a) begin errors++; $display("FAIL sb_addr: got %h expected %h", mem_addr, e.a); end
          if (mem_write_enable !== e.we) begin errors++; $display("FAIL sb_we: got %b expected %b", mem_write_enable, e.we); end
          if (mem_read_enable !== e.re) begin errors++; $display("FAIL sb_re: got %b expected %b", mem_read_enable, e.re); end
          if (e.we) begin
            checks++;
            if (mem_write_data !== e.d) begin errors++; $display("FAIL sb_wdata: got %h expected %h", mem_write_data, e.d); end
          end
        end
        mem_read_data = mem_addr ^ 16'hA5A5;
        mem_ready = 1'b1;
      end else if (!mem_read_enable && !mem_write_enable && mem_ready) mem_ready = 1'b0;
    end
  end

  // One full four-phase transaction from master m.
  task automatic master_txn(input int m, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    @(negedge clock); #1;
    rd[m] = r; wr[m] = w; addr[m] = a; wdata[m] = d;
    n = 0;
    while (!req_ready[m] && n < 200) begin @(negedge clock); #1; n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL ready_wait m%0d: got 0 expected 1", m); end
    if (r && !w) begin
      checks++;
      if (req_read_data !== (a ^ 16'hA5A5)) begin
        errors++; $display("FAIL rdata m%0d: got %h expected %h", m, req_read_data, a ^ 16'hA5A5);
      end
    end
    rd[m] = 1'b0; wr[m] = 1'b0;
    n = 0;
    while (grant[m] && n < 200) begin @(negedge clock); #1; n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL release_wait m%0d: got 1 expected 0", m); end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rd = '0; wr = '0; addr = '0; wdata = '0;
    reset = 1'b1;
    rd[0] = 1'b1; wr[1] = 1'b1; addr[0] = 16'h1234; wdata[1] = 16'h5678;
    @(posedge clock); #1;
    checks += 6;
    if (grant !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b expected 000", grant); end
    if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL rst_re: got %b expected 0", mem_read_enable); end
    if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", mem_write_enable); end
    if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_addr); end
    if (mem_write_data !== 16'h0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", mem_write_data); end
    if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready: got %b expected 000", req_ready); end
`ifdef MEM_ARBITER_TIMEOUT_EN
    checks++;
    if (timeout_error !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout_error); end
`endif
    rd = '0; wr = '0; addr = '0; wdata = '0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL idle_grant: got %b expected 000", grant); end
  endtask

  task automatic test_single_write();
    sb.push_back('{3'b010, 16'h40, 16'h3, 1'b1, 1'b0});
    @(negedge clock); #1;
    wr[1] = 1'b1; addr[1] = 16'h40; wdata[1] = 16'h3;
    @(posedge clock); #1;
    checks += 5;
    if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", mem_write_enable); end
    if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL sw_re: got %b expected 0", mem_read_enable); end
    if (mem_addr !== 16'h40) begin errors++; $display("FAIL sw_addr: got %h expected 40", mem_addr); end
    if (mem_write_data !== 16'h3) begin errors++; $display("FAIL sw_wdata: got %h expected 3", mem_write_data); end
    if (grant !== 3'b010) begin errors++; $display("FAIL sw_grant: got %b expected 010", grant); end
    @(negedge clock); #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL sw_ready_hi: got %b expected 010", req_ready); end
    wr[1] = 1'b0;
    @(negedge clock); #1;
    checks += 2;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL sw_ready_lo: got %b expected 000", req_ready); end
    if (grant !== 3'b010) begin errors++; $display("FAIL sw_grant_rel: got %b expected 010", grant); end
    @(posedge clock); #1;
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL sw_grant_clr: got %b expected 000", grant); end
  endtask

  task automatic test_simultaneous();
    int leak, gap, n;
    leak = 0; gap = 0;
    sb.push_back('{3'b001, 16'h10, 16'h0, 1'b0, 1'b1});
    sb.push_back('{3'b010, 16'h20, 16'h77, 1'b1, 1'b0});
    fork
      master_txn(0, 1'b1, 1'b0, 16'h10, 16'h0);
      master_txn(1, 1'b0, 1'b1, 16'h20, 16'h77);
      begin
        n = 0;
        while (!grant[0] && n < 100) begin @(negedge clock); #1; n++; end
        while (grant[0] && n < 100) begin
          if (req_ready[1]) leak = 1;
          @(negedge clock); #1; n++;
        end
        while (!grant[1] && n < 100) begin gap++; @(negedge clock); #1; n++; end
      end
    join
    checks += 2;
    if (leak !== 0) begin errors++; $display("FAIL sim_holdoff: got %0d expected 0", leak); end
    if (gap !== 1) begin errors++; $display("FAIL sim_idle_gap: got %0d expected 1", gap); end
  endtask

  task automatic test_dual_enable();
    sb.push_back('{3'b001, 16'h50, 16'h5, 1'b1, 1'b0});
    master_txn(0, 1'b1, 1'b1, 16'h50, 16'h5);
    sb.push_back('{3'b100, 16'h70, 16'h0, 1'b0, 1'b1});
    master_txn(2, 1'b1, 1'b0, 16'h70, 16'h0);
  endtask

  task automatic test_fairness();
    int exp_g[6];
    exp_g = '{0, 1, 2, 0, 1, 2};
    glog.delete();
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < N; m++)
        sb.push_back('{3'(1 << m), 16'(16'h100 * (m + 1) + r), 16'(m + r), 1'b1, 1'b0});
    fork
      for (int r = 0; r < 2; r++) master_txn(0, 1'b0, 1'b1, 16'(16'h100 + r), 16'(r));
      for (int r = 0; r < 2; r++) master_txn(1, 1'b0, 1'b1, 16'(16'h200 + r), 16'(1 + r));
      for (int r = 0; r < 2; r++) master_txn(2, 1'b0, 1'b1, 16'(16'h300 + r), 16'(2 + r));
    join
    checks++;
    if (glog.size() != 6) begin errors++; $display("FAIL fair_count: got %0d expected 6", glog.size()); end
    for (int i = 0; i < 6 && i < glog.size(); i++) begin
      checks++;
      if (glog[i] != exp_g[i]) begin errors++; $display("FAIL fair_seq[%0d]: got %0d expected %0d", i, glog[i], exp_g[i]); end
    end
  endtask

  task automatic test_reset_mid_active();
    resp_en = 1'b0;
    @(negedge clock); #1;
    wr[1] = 1'b1; addr[1] = 16'h22; wdata[1] = 16'h2;
    @(posedge clock); #1;
    checks++;
    if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL mr_we_before: got %b expected 1", mem_write_enable); end
    #2 reset = 1'b1;
    #1;
    checks += 2;
    if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL mr_we_async: got %b expected 0", mem_write_enable); end
    if (grant !== 3'b000) begin errors++; $display("FAIL mr_grant_async: got %b expected 000", grant); end
    rd[0] = 1'b1; addr[0] = 16'h11;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (grant !== 3'b001) begin errors++; $display("FAIL mr_first_grant: got %b expected 001", grant); end
    sb.push_back('{3'b001, 16'h11, 16'h0, 1'b0, 1'b1});
    sb.push_back('{3'b010, 16'h22, 16'h2, 1'b1, 1'b0});
    resp_en = 1'b1;
    fork
      master_txn(0, 1'b1, 1'b0, 16'h11, 16'h0);
      master_txn(1, 1'b0, 1'b1, 16'h22, 16'h2);
    join
  endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int cnt, n, stray;
    apply_reset();
    resp_en = 1'b0;
    @(negedge clock); #1;
    wr[1] = 1'b1; addr[1] = 16'h99; wdata[1] = 16'h1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (mem_write_enable) cnt++;
      if (i == 1) begin rd[0] = 1'b1; addr[0] = 16'h33; end
    end
    checks += 3;
    if (cnt != 8) begin errors++; $display("FAIL to_active_cycles: got %0d expected 8", cnt); end
    if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_error: got %b expected 1", timeout_error); end
    if (grant !== 3'b001) begin errors++; $display("FAIL to_next_grant: got %b expected 001", grant); end
    sb.push_back('{3'b001, 16'h33, 16'h0, 1'b0, 1'b1});
    resp_en = 1'b1;
    master_txn(0, 1'b1, 1'b0, 16'h33, 16'h0);
    stray = 0;
    for (n = 0; n < 4; n++) begin
      @(negedge clock); #1;
      if (grant !== 3'b000) stray = 1;
    end
    checks += 2;
    if (stray != 0) begin errors++; $display("FAIL to_blocked: got %0d expected 0", stray); end
    if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_error); end
    wr[1] = 1'b0;
    @(negedge clock); @(negedge clock);
    sb.push_back('{3'b010, 16'h99, 16'h1, 1'b1, 1'b0});
    master_txn(1, 1'b0, 1'b1, 16'h99, 16'h1);
    checks++;
    if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_sticky_end: got %b expected 1", timeout_error); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; resp_en = 1'b1;
    reset = 1'b1; rd = '0; wr = '0; addr = '0; wdata = '0;
    test_reset();
    test_single_write();
    test_simultaneous();
    test_dual_enable();
    test_fairness();
    test_reset_mid_active();
`ifdef MEM_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
